// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped, read-only instruction cache.
// Contents: geometry constants, the two-state controller enum, the refill
// line type and a saturating increment helper for the event counters.
package icache_pkg;

  localparam int ICACHE_LINES = 4;
  localparam int ICACHE_WORDS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  typedef logic [127:0] icache_line_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache.
// Ports:
//   clock, reset          - core clock, async active-high reset (clears valid bits only)
//   rd_index              - combinational read port index
//   rd_valid/rd_tag/rd_line - contents of the addressed line
//   wr_en/wr_index/wr_tag/wr_line - synchronous write port; a write also sets valid
module icache_line_array
  import icache_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 28
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output icache_line_t       rd_line,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  icache_line_t       wr_line
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  icache_line_t     data_mem [LINES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data carry no reset; a line is only ever read through its valid bit.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-line refill.
// Ports:
//   clock, reset    - core clock, async active-high reset
//   addr_in         - instruction word address (PC >> 2)
//   data_out        - instruction word, 0 whenever there is no hit
//   data_out_valid  - combinational hit indication
//   mem_addr        - line-aligned word address of the outstanding refill
//   mem_req         - refill request, held until mem_valid
//   mem_dataOut     - refill line, word 0 in bits [31:0]
//   mem_valid       - single-cycle refill strobe
// Handshake: mem_req rises the cycle after a miss and stays high with a
// stable mem_addr until a cycle in which mem_valid=1; that cycle writes the
// line and mem_req is low from the next cycle on. mem_valid outside a
// refill is ignored.
// Debug: the controller state is visible as `state`; hit_count and
// miss_count are readable hierarchically.
module icache
  import icache_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int WORDS = ICACHE_WORDS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  addr_in,
  output logic [31:0]  data_out,
  output logic         data_out_valid,
  output logic [31:0]  mem_addr,
  output logic         mem_req,
  input  icache_line_t mem_dataOut,
  input  logic         mem_valid
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  icache_state_t state;
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  icache_line_t     rd_line;
  logic [31:0]      words [WORDS];
  logic             hit;
  logic             fill_done;

  assign offset = addr_in[OFF_W-1:0];
  assign index  = addr_in[OFF_W +: IDX_W];
  assign tag    = addr_in[31 -: TAG_W];

  assign hit       = (state == IDLE) && rd_valid && (rd_tag == tag);
  assign fill_done = (state == FILL) && mem_valid;

  always_comb begin
    for (int w = 0; w < WORDS; w++) begin
      words[w] = rd_line[w*32 +: 32];
    end
  end

  always_comb begin
    data_out = '0;
    if (hit) begin
      data_out = words[offset];
    end
  end

  assign data_out_valid = hit;

  // mem_addr doubles as the captured miss address: index and tag of the
  // line being refilled come from its upper bits.
  icache_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill_done),
    .wr_index (mem_addr[OFF_W +: IDX_W]),
    .wr_tag   (mem_addr[31 -: TAG_W]),
    .wr_line  (mem_dataOut)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            hit_count <= sat_inc(hit_count);
          end else begin
            miss_count <= sat_inc(miss_count);
            mem_addr   <= {addr_in[31:OFF_W], {OFF_W{1'b0}}};
            mem_req    <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          if (mem_valid) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed cycle table, hand-written
// multi-cycle sequences, and a randomized run against a line-level model.
module tb_icache;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  addr_in;
  logic [31:0]  data_out;
  logic         data_out_valid;
  logic [31:0]  mem_addr;
  logic         mem_req;
  logic [127:0] mem_dataOut;
  logic         mem_valid;

  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q[$];

  localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L2 = 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1;
  localparam logic [127:0] L3 = 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1;
  localparam logic [127:0] L4 = 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1;
  localparam logic [127:0] LS = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;

  icache dut (
    .clock          (clock),
    .reset          (reset),
    .addr_in        (addr_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .mem_dataOut    (mem_dataOut),
    .mem_valid      (mem_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] d,
                            input logic r, input logic [31:0] ma);
    check({name, " valid"}, 128'(data_out_valid), 128'(v));
    if (v) check({name, " data"}, 128'(data_out), 128'(d));
    check({name, " mem_req"}, 128'(mem_req), 128'(r));
    if (r) check({name, " mem_addr"}, 128'(mem_addr), 128'(ma));
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at the next posedge+#1.
  task automatic cyc(input string name, input logic [31:0] a, input logic mv,
                     input logic [127:0] ln, input logic v, input logic [31:0] d,
                     input logic r, input logic [31:0] ma);
    addr_in     = a;
    mem_valid   = mv;
    mem_dataOut = ln;
    @(negedge clock);
    expect_out(name, v, d, r, ma);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string name);
    reset       = 1'b1;
    addr_in     = '0;
    mem_valid   = 1'b0;
    mem_dataOut = '0;
    #1;
    check({name, " rst mem_req"}, 128'(mem_req), 128'(0));
    check({name, " rst mem_addr"}, 128'(mem_addr), 128'(0));
    check({name, " rst valid"}, 128'(data_out_valid), 128'(0));
    check({name, " rst data"}, 128'(data_out), 128'(0));
    check({name, " rst hits"}, 128'(dut.hit_count), 128'(0));
    check({name, " rst misses"}, 128'(dut.miss_count), 128'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Memory content: each word holds its own word address scrambled by a constant.
  function automatic logic [31:0] word_of(input logic [29:0] ln, input logic [1:0] off);
    return {ln, off} ^ 32'h5A00_0000;
  endfunction

  function automatic logic [127:0] mem_line(input logic [29:0] ln);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = word_of(ln, 2'(w));
    return l;
  endfunction

  logic        slot_v [4];
  logic [29:0] slot_ln[4];

  typedef struct {
    logic [31:0] addr;
    logic        mv;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_req;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // cold miss at 0x10 with 3-cycle memory, then hits on 0x10..0x13
    vecs[0] = '{32'h10, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1] = '{32'h10, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10};
    vecs[2] = '{32'h10, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10};
    vecs[3] = '{32'h10, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10};
    vecs[4] = '{32'h10, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0};
    vecs[5] = '{32'h11, 1'b0, 1'b1, 32'h22222222, 1'b0, 32'h0};
    vecs[6] = '{32'h12, 1'b0, 1'b1, 32'h33333333, 1'b0, 32'h0};
    vecs[7] = '{32'h13, 1'b0, 1'b1, 32'h44444444, 1'b0, 32'h0};

    do_reset("cold");
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].addr, vecs[i].mv, L1,
          vecs[i].e_valid, vecs[i].e_data, vecs[i].e_req, vecs[i].e_maddr);
    end
    check("hit_count after hits", 128'(dut.hit_count), 128'(4));
    check("miss_count after hits", 128'(dut.miss_count), 128'(1));

    // conflict on index 0: 0x20 evicts 0x10
    cyc("conf miss",   32'h20, 1'b0, L1, 1'b0, 32'h0,        1'b0, 32'h0);
    cyc("conf req",    32'h20, 1'b0, L1, 1'b0, 32'h0,        1'b1, 32'h20);
    cyc("conf strobe", 32'h20, 1'b1, L2, 1'b0, 32'h0,        1'b1, 32'h20);
    cyc("conf hit",    32'h21, 1'b0, L2, 1'b1, 32'hB2B2B2B2, 1'b0, 32'h0);
    cyc("evict miss",  32'h10, 1'b0, L2, 1'b0, 32'h0,        1'b0, 32'h0);
    cyc("evict fill",  32'h10, 1'b1, L1, 1'b0, 32'h0,        1'b1, 32'h10);
    cyc("evict hit",   32'h10, 1'b0, L1, 1'b1, 32'h11111111, 1'b0, 32'h0);

    // address change mid-fill
    do_reset("midchg");
    cyc("mc miss",    32'h30, 1'b0, L3, 1'b0, 32'h0,        1'b0, 32'h0);
    cyc("mc chg",     32'h04, 1'b0, L3, 1'b0, 32'h0,        1'b1, 32'h30);
    cyc("mc strobe",  32'h04, 1'b1, L3, 1'b0, 32'h0,        1'b1, 32'h30);
    cyc("mc miss2",   32'h04, 1'b0, L3, 1'b0, 32'h0,        1'b0, 32'h0);
    cyc("mc req2",    32'h04, 1'b0, L3, 1'b0, 32'h0,        1'b1, 32'h04);
    cyc("mc strobe2", 32'h04, 1'b1, L4, 1'b0, 32'h0,        1'b1, 32'h04);
    cyc("mc hit30",   32'h33, 1'b0, L4, 1'b1, 32'hC4C4C4C4, 1'b0, 32'h0);
    cyc("mc hit04",   32'h05, 1'b0, L4, 1'b1, 32'hD2D2D2D2, 1'b0, 32'h0);

    // reset coincident with mem_valid during a fill
    do_reset("rstfill");
    cyc("rf miss", 32'h30, 1'b0, L3, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("rf req",  32'h30, 1'b0, L3, 1'b0, 32'h0, 1'b1, 32'h30);
    mem_valid   = 1'b1;
    mem_dataOut = L3;
    reset       = 1'b1;
    #1;
    check("rf mem_req immediate", 128'(mem_req), 128'(0));
    check("rf mem_addr immediate", 128'(mem_addr), 128'(0));
    check("rf valid immediate", 128'(data_out_valid), 128'(0));
    @(posedge clock);
    #1;
    reset     = 1'b0;
    mem_valid = 1'b0;
    cyc("rf remiss",  32'h30, 1'b0, L3, 1'b0, 32'h0,        1'b0, 32'h0);
    cyc("rf rereq",   32'h30, 1'b0, L3, 1'b0, 32'h0,        1'b1, 32'h30);
    cyc("rf strobe",  32'h30, 1'b1, L3, 1'b0, 32'h0,        1'b1, 32'h30);
    cyc("rf hit",     32'h30, 1'b0, L3, 1'b1, 32'hC1C1C1C1, 1'b0, 32'h0);

    // stray strobe while idle
    do_reset("stray");
    cyc("st pulse",  32'h40, 1'b1, LS, 1'b0, 32'h0,        1'b0, 32'h0);
    check("st no write", 128'(dut.u_array.valid), 128'(0));
    cyc("st req",    32'h40, 1'b0, LS, 1'b0, 32'h0,        1'b1, 32'h40);
    cyc("st fill",   32'h40, 1'b1, L4, 1'b0, 32'h0,        1'b1, 32'h40);
    cyc("st hit",    32'h42, 1'b0, LS, 1'b1, 32'hD3D3D3D3, 1'b0, 32'h0);
    cyc("st miss1",  32'h04, 1'b0, LS, 1'b0, 32'h0,        1'b0, 32'h0);

    // randomized run against the line-level model
    begin
      bit          busy;
      logic [29:0] fill_ln;
      logic [29:0] ln;
      logic [31:0] cur;
      int          lat;
      int          hits;
      int          misses;
      logic        hit;
      logic [65:0] e;

      do_reset("rand");
      for (int i = 0; i < 4; i++) begin
        slot_v[i]  = 1'b0;
        slot_ln[i] = '0;
      end
      busy = 0; fill_ln = '0; lat = 0; hits = 0; misses = 0; cur = '0;

      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 3) != 0)
          cur = {($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, 22'b0, 6'($urandom_range(0, 63))};
        addr_in     = cur;
        mem_valid   = 1'b0;
        mem_dataOut = {$urandom, $urandom, $urandom, $urandom};
        if (busy && lat == 1) begin
          mem_valid   = 1'b1;
          mem_dataOut = mem_line(fill_ln);
        end else if (!busy && $urandom_range(0, 7) == 0) begin
          mem_valid = 1'b1;
        end

        ln  = cur[31:2];
        hit = 1'b0;
        if (!busy) begin
          hit = slot_v[int'(ln % 30'd4)] && (slot_ln[int'(ln % 30'd4)] == ln);
          exp_q.push_back({hit, hit ? word_of(ln, cur[1:0]) : 32'h0, 1'b0, 32'h0});
        end else begin
          exp_q.push_back({1'b0, 32'h0, 1'b1, {fill_ln, 2'b00}});
        end

        @(negedge clock);
        e = exp_q.pop_front();
        expect_out($sformatf("rand%0d", c), e[65], e[64:33], e[32], e[31:0]);

        if (!busy) begin
          if (hit) hits++;
          else begin
            misses++;
            busy    = 1;
            fill_ln = ln;
            lat     = $urandom_range(1, 4);
          end
        end else if (lat == 1) begin
          slot_v[int'(fill_ln % 30'd4)]  = 1'b1;
          slot_ln[int'(fill_ln % 30'd4)] = fill_ln;
          busy = 0;
        end else begin
          lat--;
        end
        @(posedge clock);
        #1;
      end
      check("rand hit_count", 128'(dut.hit_count), 128'(hits));
      check("rand miss_count", 128'(dut.miss_count), 128'(misses));
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset as elsewhere in the CPU.
REQ-002 clock  input  1  core clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 addr_in  input  32  instruction word address from IF (PC >> 2).
REQ-005 data_out  output  32  instruction word for addr_in; meaningful only when data_out_valid=1.
REQ-006 data_out_valid  output  1  hit indication; when it is 0, the CPU drives icache_stall.
REQ-007 mem_addr  output  32  line-aligned word address sent to IMemory, formed as {captured addr[31:2], 2'b00}.
REQ-008 mem_req  output  1  refill request to IMemory; held high until mem_valid.
REQ-009 mem_dataOut  input  128  full line from IMemory; word 0 is in bits [31:0].
REQ-010 mem_valid  input  1  single-cycle strobe; mem_dataOut is valid in the same cycle.
REQ-011 Parameter LINES, default 4: number of direct-mapped lines.
REQ-012 Parameter WORDS, default 4: words per line; fixed at 4 by the 128-bit refill width.

Function
REQ-013 Address split (LINES=4): offset=addr_in[1:0], index=addr_in[3:2], tag=addr_in[31:4].
REQ-014 Hit condition: state==IDLE and valid[index]=1 and tag_array[index]==tag.
REQ-015 A hit SHALL be combinational: data_out_valid=1 and data_out=line[index][offset] in the same cycle, with no added latency.
REQ-016 On a miss in IDLE, the cache SHALL capture addr_in, move to FILL, and assert mem_req with mem_addr on the next cycle.
REQ-017 In FILL:
  - data_out_valid SHALL be 0.
  - mem_req SHALL stay 1 and mem_addr SHALL stay stable until mem_valid.
REQ-018 When mem_valid=1 in FILL, the cache SHALL write the line, tag and valid bit for the captured index, drop mem_req in the following cycle, and return to IDLE.
REQ-019 Miss penalty: the first hit is reported the cycle after the mem_valid cycle (penalty = memory latency + 1).
REQ-020 If addr_in changes during FILL, the fill SHALL still complete for the captured address; IDLE then evaluates the current addr_in, and a further miss starts a new fill.
REQ-021 mem_valid received while in IDLE SHALL be ignored, with no array write.
REQ-022 A conflicting tag on a valid line SHALL be replaced on refill; there is no write-back because the cache is read-only.
REQ-023 Two 32-bit saturating counters, hit_count and miss_count, SHALL count IDLE hits and IDLE misses; they are readable hierarchically.
REQ-024 State encoding SHALL be IDLE and FILL only; no other state may be reachable.

Reset
REQ-025 On reset assertion the cache SHALL immediately:
  - go to state IDLE;
  - clear all valid bits;
  - drive mem_req=0, mem_addr=0 and data_out_valid=0;
  - clear both counters.
REQ-026 Reset asserted during FILL SHALL abandon the refill, with no array write even if mem_valid is coincident.
REQ-027 The data and tag arrays need not be reset; only the valid bits are significant.
REQ-028 data_out SHALL reset to 0.

Structure
REQ-029 A shared package SHALL hold:
  - ICACHE_LINES and ICACHE_WORDS;
  - the state enum icache_state_t (IDLE, FILL);
  - the line typedef icache_line_t (logic [127:0]).
REQ-030 Storage SHALL be a single sub-module, icache_line_array, providing valid, tag and data storage with one combinational read port and one synchronous write port.
REQ-031 The FSM, address capture and counters SHALL live in icache itself.

Verification
REQ-032 Cold miss: reset, then addr_in=0x10, with memory returning 0x44444444_33333333_22222222_11111111 after 3 cycles.
  - Required: mem_req=1 and mem_addr=0x10 for 3 cycles.
  - Required: data_out=0x11111111 with data_out_valid=1 one cycle after mem_valid; miss_count=1.
REQ-033 Hit sequence: after REQ-032, apply addr_in=0x11, 0x12, 0x13 on consecutive cycles.
  - Required: data_out_valid=1 each cycle, data_out=0x22222222, 0x33333333, 0x44444444, mem_req=0, hit_count=4.
REQ-034 Conflict: after REQ-032, apply addr_in=0x20 (index 0, different tag).
  - Required: miss and refill at mem_addr=0x20.
  - Required: a subsequent addr_in=0x10 misses again.
REQ-035 Address change mid-fill: on a miss at 0x30, change addr_in to 0x04 before mem_valid.
  - Required: the line for 0x30 is installed.
  - Required: a second fill starts at mem_addr=0x04.
REQ-036 Reset mid-fill: assert reset in the same cycle as mem_valid during a fill of 0x30.
  - Required: mem_req=0 immediately.
  - Required: a following access to 0x30 misses.
REQ-037 Stray strobe: pulse mem_valid in IDLE with an empty cache.
  - Required: no line becomes valid; the next access misses.
